lcd_bus_responder: RTL and testbench
====================================

# lcd_bus_responder

Synthesizable model of the HD44780-compatible character LCD controller, 8-bit bus, 2×16 display: the responding end of the RS/RW/E/DB bus that the display driver side of the design produces. It captures command and data writes on E falling edges, maintains a 32-character DDRAM, address counter, display-control flags and busy flag, and answers status and data reads. It sits in the test harness and FPGA loopback builds in place of the physical LCD. A debug port lets a checker read the displayed text.

## Interface
- BUSY_SHORT, 2000 — busy duration in clocks for ordinary commands and data writes (40 µs at 50 MHz).
- BUSY_LONG, 76500 — busy duration for clear display and return home, and after reset (1.53 ms); must be ≥ 32.
- clock50MHz  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high.
- RS, RW, E  input  1 each  LCD bus controls, asynchronous to clock50MHz.
- DB_in  input  8  bus data from the driver.
- DB_out  output  8  read data.
- DB_oe  output  1  high while responder drives the bus.
- dbg_index  input  5  character index: 0–15 line 1, 16–31 line 2.
- dbg_char  output  8  DDRAM byte at dbg_index, combinational.
- busy  output  1  busy flag.
- display_on, cursor_on, blink_on, entry_inc, entry_shift  output  1 each  control flags.
- protocol_err  output  1  sticky error flag.

## Operation
- RS, RW, E, DB_in pass through a 2-flop synchronizer. E falling edge is detected on the synchronized E (sync-E previous = 1, current = 0). RS/RW/DB are sampled in the same cycle from their synchronized copies.
- Address counter AC is 7 bits. Only 0x00–0x0F and 0x40–0x4F are valid. DDRAM index = {AC[6], AC[3:0]}.
- AC increment wraps 0x0F→0x40 and 0x4F→0x00. Decrement wraps 0x00→0x4F and 0x40→0x0F.
- Write, RS=0, command decoded by highest set bit:
  - 0x01 clear: DDRAM sweep-filled with 0x20, one location per clock over 32 clocks. AC=0, entry_inc=1. Busy for BUSY_LONG.
  - 0x02/0x03 return home: AC=0. Busy for BUSY_LONG.
  - 0x04–0x07 entry mode: entry_inc=DB[1], entry_shift=DB[0].
  - 0x08–0x0F display control: display_on=DB[2], cursor_on=DB[1], blink_on=DB[0].
  - 0x10–0x1F cursor/display shift: if DB[3]=0, AC moves ±1 per DB[2] using the wrap rules. If DB[3]=1, no state change.
  - 0x20–0x3F function set: accepted, no state change.
  - 0x40–0x7F CGRAM address: accepted, ignored.
  - 0x80–0xFF set DDRAM address: AC = {DB[6], 2'b00, DB[3:0]}.
  - 0x00: no-op, not busy.
  - All commands except 0x00, clear and home set busy for BUSY_SHORT.
- Write, RS=1: DDRAM[AC] = DB. AC steps per entry_inc. Busy for BUSY_SHORT.
- Read, RW=1:
  - DB_oe = sync-E & sync-RW.
  - RS=0: DB_out = {busy, AC}, registered each clock. No side effect.
  - RS=1: DB_out = DDRAM[AC]. AC steps on the E falling edge. No busy.
- Any write or data read whose E falling edge occurs while busy=1 is dropped and sets protocol_err. Status reads while busy are always legal.
- protocol_err clears only on reset.
- Reset: AC=0. display_on=cursor_on=blink_on=entry_shift=0, entry_inc=1, protocol_err=0, DB_out=0, DB_oe=0, busy=1. On release, a clear sweep runs automatically and busy holds for BUSY_LONG clocks.
- States: SWEEP (clearing DDRAM), BUSY (counting down), IDLE. SWEEP runs inside the busy window.

## Timing
- Latency: E pin falls at clock n → edge detected at n+2 → AC/DDRAM/flags updated and busy=1 at n+3.
- Busy holds for exactly BUSY_x clocks, then deasserts; busy=0 at edge+1+BUSY_x.
- Clear sweep writes index k at sweep cycle k (0..31). dbg_char reflects each write the following cycle.
- Reset asserted mid-sweep or mid-busy aborts it. All outputs take reset values asynchronously. The sweep restarts on release.
- DB_out/DB_oe lag the E/RW pins by 2–3 clocks. Readback is valid while E has been high ≥ 3 clocks.

## Test plan
- Reset release → busy=1 for 76500 clocks. Afterwards dbg_char=0x20 for all 32 indices; status read returns 0x00.
- After busy clears, write 0x0C then data "AB" → display_on=1, cursor_on=0; dbg_char[0]=0x41, dbg_char[1]=0x42; status read = 0x02 once not busy.
- Set address 0x8F, write data 0x58, then status read → dbg_char[15]=0x58, AC=0x40. Set 0xCF, write a byte → AC wraps to 0x00.
- Entry mode 0x04, set address 0xC0, write data → AC=0x0F (decrement wrap).
- Data write issued 100 clocks after a previous write, with BUSY_SHORT=2000 → write dropped, DDRAM unchanged, protocol_err=1 and stays 1.
- Write 0x01 during a normal session, then assert reset at sweep cycle 10 → all outputs at reset values immediately. After release, full sweep and BUSY_LONG wait complete.

Source files
------------

// File: rtl/lcd_bus_responder.sv
// Responding end of an HD44780-style 8-bit LCD bus for a 2x16 display. Captures
// writes on E falling edges, keeps DDRAM/AC/flags/busy, and answers status/data reads.
module lcd_bus_responder #(
    parameter int BUSY_SHORT = 2000,
    parameter int BUSY_LONG  = 76500
) (
    input  logic       clock50MHz,
    input  logic       reset,
    input  logic       RS,
    input  logic       RW,
    input  logic       E,
    input  logic [7:0] DB_in,
    output logic [7:0] DB_out,
    output logic       DB_oe,
    input  logic [4:0] dbg_index,
    output logic [7:0] dbg_char,
    output logic       busy,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       entry_shift,
    output logic       protocol_err
);

    localparam int CNT_MAX = (BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_SHORT = CW'(BUSY_SHORT);
    localparam logic [CW-1:0] CNT_LONG  = CW'(BUSY_LONG);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [1:0] ST_SWEEP = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_IDLE  = 2'd2;

    // Bus pins packed as {DB[7:0], RS, RW, E}
    logic [10:0] pins;
    logic [10:0] sync1_q, sync2_q;
    logic        e_prev_q;
    logic        e_s, rw_s, rs_s, e_fall;
    logic [7:0]  db_s;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    sweep_idx_q, sweep_idx_d;
    logic [6:0]    ac_q, ac_d;
    logic          disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic          inc_q, inc_d, shift_q, shift_d, err_q, err_d;
    logic [7:0]    db_out_q, db_out_d;

    logic [7:0] ram_q [32];
    logic       ram_we;
    logic [4:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic [4:0] ac_idx;

    assign pins   = {DB_in, RS, RW, E};
    assign e_s    = sync2_q[0];
    assign rw_s   = sync2_q[1];
    assign rs_s   = sync2_q[2];
    assign db_s   = sync2_q[10:3];
    assign e_fall = e_prev_q & ~e_s;
    assign ac_idx = {ac_q[6], ac_q[3:0]};

    // Both lines are 16 wide; stepping past a line end lands on the other line.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (ac[3:0] == 4'hF) r = {~ac[6], 6'b000000};
            else                 r = ac + 7'd1;
        end else begin
            if (ac[3:0] == 4'h0) r = {~ac[6], 2'b00, 4'hF};
            else                 r = ac - 7'd1;
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sweep_idx_d = sweep_idx_q;
        ac_d        = ac_q;
        disp_d      = disp_q;
        cur_d       = cur_q;
        blink_d     = blink_q;
        inc_d       = inc_q;
        shift_d     = shift_q;
        err_d       = err_q;
        ram_we      = 1'b0;
        ram_waddr   = sweep_idx_q;
        ram_wdata   = 8'h20;

        case (state_q)
            ST_SWEEP: begin
                ram_we      = 1'b1;
                sweep_idx_d = sweep_idx_q + 5'd1;
                cnt_d       = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE)          state_d = ST_IDLE;
                else if (sweep_idx_q == 5'd31) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) state_d = ST_IDLE;
            end
            default: ;
        endcase

        if (e_fall && !(rw_s && !rs_s)) begin
            if (state_q != ST_IDLE) begin
                err_d = 1'b1;
            end else if (rw_s) begin
                ac_d = ac_step(ac_q, inc_q);
            end else if (rs_s) begin
                ram_we    = 1'b1;
                ram_waddr = ac_idx;
                ram_wdata = db_s;
                ac_d      = ac_step(ac_q, inc_q);
                state_d   = ST_BUSY;
                cnt_d     = CNT_SHORT;
            end else begin
                state_d = ST_BUSY;
                cnt_d   = CNT_SHORT;
                casez (db_s)
                    8'b1???????: ac_d = {db_s[6], 2'b00, db_s[3:0]};
                    8'b01??????: ;
                    8'b001?????: ;
                    8'b0001????: if (!db_s[3]) ac_d = ac_step(ac_q, db_s[2]);
                    8'b00001???: begin
                        disp_d  = db_s[2];
                        cur_d   = db_s[1];
                        blink_d = db_s[0];
                    end
                    8'b000001??: begin
                        inc_d   = db_s[1];
                        shift_d = db_s[0];
                    end
                    8'b0000001?: begin
                        ac_d  = 7'd0;
                        cnt_d = CNT_LONG;
                    end
                    8'b00000001: begin
                        ac_d        = 7'd0;
                        inc_d       = 1'b1;
                        state_d     = ST_SWEEP;
                        sweep_idx_d = 5'd0;
                        cnt_d       = CNT_LONG;
                    end
                    default: begin
                        state_d = state_q;
                        cnt_d   = cnt_q;
                    end
                endcase
            end
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign db_out_d = rs_s ? ram_q[ac_idx] : {busy, ac_q};

    always_ff @(posedge clock50MHz or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            e_prev_q    <= 1'b0;
            state_q     <= ST_SWEEP;
            cnt_q       <= CNT_LONG;
            sweep_idx_q <= 5'd0;
            ac_q        <= 7'd0;
            disp_q      <= 1'b0;
            cur_q       <= 1'b0;
            blink_q     <= 1'b0;
            inc_q       <= 1'b1;
            shift_q     <= 1'b0;
            err_q       <= 1'b0;
            db_out_q    <= 8'h00;
        end else begin
            sync1_q     <= pins;
            sync2_q     <= sync1_q;
            e_prev_q    <= e_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sweep_idx_q <= sweep_idx_d;
            ac_q        <= ac_d;
            disp_q      <= disp_d;
            cur_q       <= cur_d;
            blink_q     <= blink_d;
            inc_q       <= inc_d;
            shift_q     <= shift_d;
            err_q       <= err_d;
            db_out_q    <= db_out_d;
        end
    end

    // DDRAM has no reset: its contents are restored by the clear sweep instead.
    always_ff @(posedge clock50MHz) begin
        if (ram_we) ram_q[ram_waddr] <= ram_wdata;
    end

    assign dbg_char     = ram_q[dbg_index];
    assign DB_out       = db_out_q;
    assign DB_oe        = e_s & rw_s;
    assign display_on   = disp_q;
    assign cursor_on    = cur_q;
    assign blink_on     = blink_q;
    assign entry_inc    = inc_q;
    assign entry_shift  = shift_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Bench for lcd_bus_responder: directed steps plus random command/data traffic
// checked against a line/column model of the display.
module tb_lcd_bus_responder;

    localparam int BS = 40;
    localparam int BL = 120;

    logic       clk = 1'b0;
    logic       rst;
    logic       RS, RW, E;
    logic [7:0] DB_in, DB_out, dbg_char;
    logic [4:0] dbg_index;
    logic       DB_oe, busy, display_on, cursor_on, blink_on, entry_inc, entry_shift, protocol_err;

    always #10 clk = ~clk;

    lcd_bus_responder #(.BUSY_SHORT(BS), .BUSY_LONG(BL)) dut (
        .clock50MHz(clk), .reset(rst), .RS(RS), .RW(RW), .E(E), .DB_in(DB_in),
        .DB_out(DB_out), .DB_oe(DB_oe), .dbg_index(dbg_index), .dbg_char(dbg_char),
        .busy(busy), .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .entry_inc(entry_inc), .entry_shift(entry_shift), .protocol_err(protocol_err)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_ram [32];
    int m_line, m_col;
    bit m_inc, m_shift, m_disp, m_cur, m_blink, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_idx();
        return m_line * 16 + m_col;
    endfunction

    function automatic logic [7:0] m_status();
        return 8'(m_line * 64 + m_col);
    endfunction

    function automatic void m_step(input bit inc);
        if (inc) begin
            if (m_col == 15) begin m_col = 0; m_line = 1 - m_line; end
            else m_col++;
        end else begin
            if (m_col == 0) begin m_col = 15; m_line = 1 - m_line; end
            else m_col--;
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
        m_line = 0; m_col = 0;
        m_inc = 1; m_shift = 0; m_disp = 0; m_cur = 0; m_blink = 0; m_err = 0;
    endfunction

    // Applies a command to the model and returns the busy length it should cause.
    function automatic int m_cmd(input int c);
        if (c >= 128) begin
            m_line = (c >> 6) & 1;
            m_col  = c & 15;
            return BS;
        end
        if (c >= 32) return BS;
        if (c >= 16) begin
            if (((c >> 3) & 1) == 0) m_step(((c >> 2) & 1) == 1);
            return BS;
        end
        if (c >= 8) begin
            m_disp = (c >> 2) & 1; m_cur = (c >> 1) & 1; m_blink = c & 1;
            return BS;
        end
        if (c >= 4) begin
            m_inc = (c >> 1) & 1; m_shift = c & 1;
            return BS;
        end
        if (c >= 2) begin
            m_line = 0; m_col = 0;
            return BL;
        end
        if (c == 1) begin
            for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
            m_line = 0; m_col = 0; m_inc = 1;
            return BL;
        end
        return 0;
    endfunction

    task automatic bus_write(input logic rs, input logic [7:0] d);
        @(negedge clk); RS = rs; RW = 1'b0; DB_in = d;
        @(negedge clk); E = 1'b1;
        repeat (3) @(negedge clk);
        E = 1'b0;
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] d, output logic oe);
        @(negedge clk); RS = rs; RW = 1'b1;
        @(negedge clk); E = 1'b1;
        repeat (5) @(negedge clk);
        d = DB_out; oe = DB_oe;
        E = 1'b0;
        repeat (4) @(negedge clk);
        RW = 1'b0;
    endtask

    // Called right after E falls: busy must rise 3 clocks later and last exactly n clocks.
    task automatic expect_busy(input int n, input string tag);
        int cnt;
        cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        while (busy === 1'b1 && cnt < n + 50) begin cnt++; @(negedge clk); end
        chk(tag, cnt, n);
    endtask

    task automatic cmd(input logic [7:0] c);
        int n;
        n = m_cmd(int'(c));
        bus_write(1'b0, c);
        expect_busy(n, $sformatf("busy_cmd_%02h", c));
    endtask

    task automatic wdata(input logic [7:0] d);
        m_ram[m_idx()] = d;
        m_step(m_inc);
        bus_write(1'b1, d);
        expect_busy(BS, "busy_data");
    endtask

    task automatic rd_status(input string tag);
        logic [7:0] d;
        logic oe;
        bus_read(1'b0, d, oe);
        chk(tag, d, m_status());
        chk({tag, "_oe"}, oe, 1'b1);
    endtask

    task automatic rd_data(input string tag);
        logic [7:0] d;
        logic oe;
        bus_read(1'b1, d, oe);
        chk(tag, d, m_ram[m_idx()]);
        chk({tag, "_oe"}, oe, 1'b1);
        m_step(m_inc);
    endtask

    task automatic check_dbg(input int idx, input logic [7:0] exp);
        dbg_index = 5'(idx);
        #1;
        chk($sformatf("dbg_char[%0d]", idx), dbg_char, exp);
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_display_on"}, display_on, m_disp);
        chk({tag, "_cursor_on"}, cursor_on, m_cur);
        chk({tag, "_blink_on"}, blink_on, m_blink);
        chk({tag, "_entry_inc"}, entry_inc, m_inc);
        chk({tag, "_entry_shift"}, entry_shift, m_shift);
        chk({tag, "_protocol_err"}, protocol_err, m_err);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_db_out"}, DB_out, 8'h00);
        chk({tag, "_db_oe"}, DB_oe, 1'b0);
        chk({tag, "_display_on"}, display_on, 1'b0);
        chk({tag, "_cursor_on"}, cursor_on, 1'b0);
        chk({tag, "_blink_on"}, blink_on, 1'b0);
        chk({tag, "_entry_inc"}, entry_inc, 1'b1);
        chk({tag, "_entry_shift"}, entry_shift, 1'b0);
        chk({tag, "_protocol_err"}, protocol_err, 1'b0);
    endtask

    task automatic release_and_check(input string tag);
        int cnt;
        cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        while (busy === 1'b1 && cnt < BL + 50) begin cnt++; @(negedge clk); end
        chk({tag, "_busy_len"}, cnt, BL);
        for (int i = 0; i < 32; i++) check_dbg(i, m_ram[i]);
        rd_status({tag, "_status"});
        check_flags(tag);
    endtask

    initial begin
        int unsigned r;
        int cnt;
        rst = 1'b1; RS = 1'b0; RW = 1'b0; E = 1'b0; DB_in = 8'h00; dbg_index = 5'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        m_reset();
        release_and_check("por");

        // Display control then "AB"
        cmd(8'h0C);
        wdata(8'h41);
        wdata(8'h42);
        check_flags("after_0c");
        check_dbg(0, 8'h41);
        check_dbg(1, 8'h42);
        rd_status("status_ab");

        // Line-end wraps
        cmd(8'h8F);
        wdata(8'h58);
        rd_status("status_wrap_0f");
        check_dbg(15, 8'h58);
        cmd(8'hCF);
        wdata(8'h33);
        rd_status("status_wrap_4f");
        cmd(8'h04);
        cmd(8'hC0);
        wdata(8'h44);
        rd_status("status_wrap_dec");
        cmd(8'h06);
        cmd(8'h00);

        // Data reads step AC
        cmd(8'h80);
        rd_data("rd_a");
        rd_data("rd_b");
        rd_status("status_after_rd");

        // Write during busy is dropped and latches protocol_err
        cmd(8'h83);
        m_ram[m_idx()] = 8'h77;
        m_step(m_inc);
        bus_write(1'b1, 8'h77);
        repeat (10) @(negedge clk);
        bus_write(1'b1, 8'h99);
        m_err = 1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 4 * BS) begin cnt++; @(negedge clk); end
        chk("drop_idle_timeout", cnt < 4 * BS, 1'b1);
        chk("drop_protocol_err", protocol_err, 1'b1);
        check_dbg(3, m_ram[3]);
        check_dbg(4, m_ram[4]);
        rd_status("status_drop");

        // Random traffic against the model
        for (int k = 0; k < 60; k++) begin
            r = $urandom;
            case (r % 8)
                0: wdata(8'($urandom));
                1: cmd(8'h80 | 8'($urandom & 32'h7F));
                2: cmd(8'h04 | 8'($urandom & 32'h3));
                3: cmd(8'h08 | 8'($urandom & 32'h7));
                4: cmd(8'h10 | 8'($urandom & 32'hF));
                5: rd_data($sformatf("rnd_rd_%0d", k));
                6: rd_status($sformatf("rnd_status_%0d", k));
                default: cmd(8'h20 | 8'($urandom & 32'h5F));
            endcase
        end
        check_flags("rnd_end");
        for (int i = 0; i < 32; i++) check_dbg(i, m_ram[i]);

        // Clear, then reset at sweep cycle 10
        cmd(8'h85);
        wdata(8'h66);
        cmd(8'hC4);
        wdata(8'h5A);
        cmd(8'h0F);
        cmd(8'h07);
        check_flags("pre_clear");
        bus_write(1'b0, 8'h01);
        repeat (13) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_sweep");
        check_dbg(5, 8'h20);
        check_dbg(20, 8'h5A);
        repeat (3) @(negedge clk);
        m_reset();
        release_and_check("rerelease");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
